alu_station: RTL and testbench

Single-entry reservation station and execution unit for one ALU slot, directly downstream of the dispatch allocator. It accepts one issued ALU instruction, snoops the three write-back buses until both operands are resolved, computes the 32-bit result, and broadcasts it for one cycle on its own write-back bus. Two instances exist in the design: one with `SELF_TAG=1` (ALU_MASTER, drives bus 0) and one with `SELF_TAG=2` (ALU_SALVER, drives bus 1).

---
 rtl/alu_station.sv | 181 ++++++++++++++++++
 tb/tb_alu_station.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_station.sv
// alu_station: single-entry ALU reservation station with operand snoop.
// Holds one instruction until its operands resolve, then broadcasts the result for one cycle.
module alu_station #(
  parameter int SELF_TAG = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_in,
  input  logic        en_in,
  input  logic [31:0] pc_in,
  input  logic [3:0]  op_in,
  input  logic [2:0]  tagx_in,
  input  logic [2:0]  tagy_in,
  input  logic [31:0] datax_in,
  input  logic [31:0] datay_in,
  input  logic [4:0]  addrw_in,
  input  logic        en_mw0,
  input  logic [31:0] write_data0,
  input  logic        en_mw1,
  input  logic [31:0] write_data1,
  input  logic        en_mwM,
  input  logic [31:0] write_dataM,
  output logic        busy_out,
  output logic        en_out,
  output logic [4:0]  reg_write_addr_out,
  output logic [31:0] write_data_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SLL   = 4'd2;
  localparam logic [3:0] OP_SLT   = 4'd3;
  localparam logic [3:0] OP_SLTU  = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_AND   = 4'd9;
  localparam logic [3:0] OP_LUI   = 4'd10;
  localparam logic [3:0] OP_AUIPC = 4'd11;
  localparam logic [3:0] OP_LINK  = 4'd12;

  // The slot tag only identifies the instance; nothing compares against it.
  logic unused_self_tag;
  assign unused_self_tag = ^3'(SELF_TAG);

  logic [1:0]  state;
  logic [31:0] pc_q;
  logic [3:0]  op_q;
  logic [4:0]  addrw_q;
  logic [2:0]  tagx_q;
  logic [2:0]  tagy_q;
  logic [31:0] datax_q;
  logic [31:0] datay_q;

  logic        x_hit, y_hit, ix_hit, iy_hit;
  logic [31:0] x_bus, y_bus, ix_bus, iy_bus;
  logic        x_rdy, y_rdy;
  logic [31:0] x_eff, y_eff;
  logic [31:0] result;

  function automatic logic snoop_hit(input logic [2:0] t,
                                     input logic m0,
                                     input logic m1,
                                     input logic mm);
    return (t == 3'd1 && m0) ||
           (t == 3'd2 && m1) ||
           (t == 3'd3 && mm);
  endfunction

  function automatic logic [31:0] snoop_data(input logic [2:0]  t,
                                             input logic [31:0] d0,
                                             input logic [31:0] d1,
                                             input logic [31:0] dm);
    logic [31:0] d;
    d = d0;
    if (t == 3'd2) d = d1;
    if (t == 3'd3) d = dm;
    return d;
  endfunction

  assign busy_out = (state == S_WAIT);

  // Resolve held and incoming operands against the three write-back buses.
  always_comb begin
    x_hit  = snoop_hit(tagx_q, en_mw0, en_mw1, en_mwM);
    y_hit  = snoop_hit(tagy_q, en_mw0, en_mw1, en_mwM);
    ix_hit = snoop_hit(tagx_in, en_mw0, en_mw1, en_mwM);
    iy_hit = snoop_hit(tagy_in, en_mw0, en_mw1, en_mwM);
    x_bus  = snoop_data(tagx_q, write_data0, write_data1, write_dataM);
    y_bus  = snoop_data(tagy_q, write_data0, write_data1, write_dataM);
    ix_bus = snoop_data(tagx_in, write_data0, write_data1, write_dataM);
    iy_bus = snoop_data(tagy_in, write_data0, write_data1, write_dataM);
    x_rdy  = (tagx_q == 3'd0) || x_hit;
    y_rdy  = (tagy_q == 3'd0) || y_hit;
    x_eff  = (tagx_q == 3'd0) ? datax_q : x_bus;
    y_eff  = (tagy_q == 3'd0) ? datay_q : y_bus;
  end

  // ALU on the effective operands; undefined sub-ops yield zero.
  always_comb begin
    result = 32'd0;
    case (op_q)
      OP_ADD:   result = x_eff + y_eff;
      OP_SUB:   result = x_eff - y_eff;
      OP_SLL:   result = x_eff << y_eff[4:0];
      OP_SLT:   result = {31'd0, $signed(x_eff) < $signed(y_eff)};
      OP_SLTU:  result = {31'd0, x_eff < y_eff};
      OP_XOR:   result = x_eff ^ y_eff;
      OP_SRL:   result = x_eff >> y_eff[4:0];
      OP_SRA:   result = $unsigned($signed(x_eff) >>> y_eff[4:0]);
      OP_OR:    result = x_eff | y_eff;
      OP_AND:   result = x_eff & y_eff;
      OP_LUI:   result = y_eff;
      OP_AUIPC: result = pc_q + y_eff;
      OP_LINK:  result = pc_q + 32'd4;
      default:  result = 32'd0;
    endcase
  end

  // Station FSM: issue, snoop while waiting, one-cycle result broadcast.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= S_IDLE;
      pc_q               <= 32'd0;
      op_q               <= 4'd0;
      addrw_q            <= 5'd0;
      tagx_q             <= 3'd0;
      tagy_q             <= 3'd0;
      datax_q            <= 32'd0;
      datay_q            <= 32'd0;
      en_out             <= 1'b0;
      reg_write_addr_out <= 5'd0;
      write_data_out     <= 32'd0;
    end else begin
      en_out <= 1'b0;
      if (clear_in) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_WAIT: begin
            if (x_rdy && y_rdy) begin
              write_data_out     <= result;
              reg_write_addr_out <= addrw_q;
              en_out             <= 1'b1;
              state              <= S_DONE;
            end else begin
              if (x_hit) begin
                tagx_q  <= 3'd0;
                datax_q <= x_bus;
              end
              if (y_hit) begin
                tagy_q  <= 3'd0;
                datay_q <= y_bus;
              end
            end
          end
          default: begin
            if (en_in) begin
              pc_q    <= pc_in;
              op_q    <= op_in;
              addrw_q <= addrw_in;
              tagx_q  <= ix_hit ? 3'd0 : tagx_in;
              datax_q <= ix_hit ? ix_bus : datax_in;
              tagy_q  <= iy_hit ? 3'd0 : tagy_in;
              datay_q <= iy_hit ? iy_bus : datay_in;
              state   <= S_WAIT;
            end else begin
              state <= S_IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_station.sv
// tb_alu_station: directed vectors and corner sequences for alu_station.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_alu_station;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_in;
  logic        en_in;
  logic [31:0] pc_in;
  logic [3:0]  op_in;
  logic [2:0]  tagx_in, tagy_in;
  logic [31:0] datax_in, datay_in;
  logic [4:0]  addrw_in;
  logic        en_mw0, en_mw1, en_mwM;
  logic [31:0] write_data0, write_data1, write_dataM;
  logic        busy_out, en_out;
  logic [4:0]  reg_write_addr_out;
  logic [31:0] write_data_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_station #(.SELF_TAG(1)) dut (
    .clk(clk), .rst(rst), .clear_in(clear_in), .en_in(en_in),
    .pc_in(pc_in), .op_in(op_in),
    .tagx_in(tagx_in), .tagy_in(tagy_in),
    .datax_in(datax_in), .datay_in(datay_in),
    .addrw_in(addrw_in),
    .en_mw0(en_mw0), .write_data0(write_data0),
    .en_mw1(en_mw1), .write_data1(write_data1),
    .en_mwM(en_mwM), .write_dataM(write_dataM),
    .busy_out(busy_out), .en_out(en_out),
    .reg_write_addr_out(reg_write_addr_out),
    .write_data_out(write_data_out)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] pc;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  addr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] pc,
                       input logic [2:0] tx, input logic [31:0] x,
                       input logic [2:0] ty, input logic [31:0] y,
                       input logic [4:0] addr);
    en_in    = 1'b1;
    op_in    = op;
    pc_in    = pc;
    tagx_in  = tx;
    datax_in = x;
    tagy_in  = ty;
    datay_in = y;
    addrw_in = addr;
  endtask

  initial begin
    vecs[0]  = '{4'd0,  32'h0,   32'd5,        32'd7,        5'd3,  32'd12};
    vecs[1]  = '{4'd1,  32'h0,   32'd5,        32'd7,        5'd4,  32'hFFFF_FFFE};
    vecs[2]  = '{4'd2,  32'h0,   32'd1,        32'h3F,       5'd5,  32'h8000_0000};
    vecs[3]  = '{4'd3,  32'h0,   32'hFFFF_FFFF, 32'd1,       5'd6,  32'd1};
    vecs[4]  = '{4'd4,  32'h0,   32'hFFFF_FFFF, 32'd1,       5'd7,  32'd0};
    vecs[5]  = '{4'd5,  32'h0,   32'h0000_F0F0, 32'h0000_0FF0, 5'd8, 32'h0000_FF00};
    vecs[6]  = '{4'd6,  32'h0,   32'h8000_0000, 32'd4,       5'd9,  32'h0800_0000};
    vecs[7]  = '{4'd7,  32'h0,   32'h8000_0000, 32'h21,      5'd10, 32'hC000_0000};
    vecs[8]  = '{4'd8,  32'h0,   32'hF0,       32'h0F,       5'd11, 32'hFF};
    vecs[9]  = '{4'd9,  32'h0,   32'hF0,       32'h3C,       5'd12, 32'h30};
    vecs[10] = '{4'd10, 32'h0,   32'd99,       32'h1234_5000, 5'd13, 32'h1234_5000};
    vecs[11] = '{4'd11, 32'h100, 32'd99,       32'h1000,     5'd14, 32'h1100};
    vecs[12] = '{4'd12, 32'h100, 32'd99,       32'd1,        5'd15, 32'h104};
    vecs[13] = '{4'd13, 32'h0,   32'd3,        32'd4,        5'd16, 32'd0};
    vecs[14] = '{4'd0,  32'h0,   32'hFFFF_FFFF, 32'd1,       5'd31, 32'd0};

    rst = 1'b1;
    clear_in = 1'b0;
    en_in = 1'b0;
    pc_in = '0; op_in = '0;
    tagx_in = '0; tagy_in = '0;
    datax_in = '0; datay_in = '0;
    addrw_in = '0;
    en_mw0 = 1'b0; en_mw1 = 1'b0; en_mwM = 1'b0;
    write_data0 = '0; write_data1 = '0; write_dataM = '0;

    repeat (2) @(negedge clk);
    check("reset busy", {31'd0, busy_out}, 32'd0);
    check("reset en_out", {31'd0, en_out}, 32'd0);
    check("reset addr", {27'd0, reg_write_addr_out}, 32'd0);
    check("reset data", write_data_out, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      issue(vecs[i].op, vecs[i].pc, 3'd0, vecs[i].x, 3'd0, vecs[i].y,
            vecs[i].addr);
      @(negedge clk);
      en_in = 1'b0;
      check($sformatf("v%0d busy", i), {31'd0, busy_out}, 32'd1);
      check($sformatf("v%0d en_early", i), {31'd0, en_out}, 32'd0);
      @(negedge clk);
      check($sformatf("v%0d en_out", i), {31'd0, en_out}, 32'd1);
      check($sformatf("v%0d data", i), write_data_out, vecs[i].exp);
      check($sformatf("v%0d addr", i), {27'd0, reg_write_addr_out},
            {27'd0, vecs[i].addr});
      check($sformatf("v%0d busy_done", i), {31'd0, busy_out}, 32'd0);
      @(negedge clk);
      check($sformatf("v%0d en_drop", i), {31'd0, en_out}, 32'd0);
    end

    // SUB waiting on the load/store bus for four cycles
    issue(4'd1, 32'h0, 3'd3, 32'hDEAD, 3'd0, 32'd1, 5'd2);
    @(negedge clk);
    en_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("wait busy", {31'd0, busy_out}, 32'd1);
      check("wait en", {31'd0, en_out}, 32'd0);
      @(negedge clk);
    end
    en_mwM = 1'b1;
    write_dataM = 32'h10;
    @(negedge clk);
    en_mwM = 1'b0;
    write_dataM = 32'h0;
    check("snoopM en", {31'd0, en_out}, 32'd1);
    check("snoopM data", write_data_out, 32'h0F);
    @(negedge clk);

    // x resolves at issue, y waits; then both buses fire together
    en_mw0 = 1'b1;
    write_data0 = 32'd100;
    issue(4'd0, 32'h0, 3'd1, 32'd0, 3'd2, 32'd0, 5'd7);
    @(negedge clk);
    en_in = 1'b0;
    en_mw0 = 1'b0;
    write_data0 = 32'd0;
    check("issue snoop busy", {31'd0, busy_out}, 32'd1);
    en_mw0 = 1'b1;
    write_data0 = 32'd5000;
    en_mw1 = 1'b1;
    write_data1 = 32'd23;
    @(negedge clk);
    en_mw0 = 1'b0;
    en_mw1 = 1'b0;
    check("issue snoop en", {31'd0, en_out}, 32'd1);
    check("issue snoop data", write_data_out, 32'd123);
    @(negedge clk);

    issue(4'd0, 32'h0, 3'd1, 32'd0, 3'd2, 32'd0, 5'd8);
    @(negedge clk);
    en_in = 1'b0;
    en_mw0 = 1'b1;
    write_data0 = 32'h1000;
    en_mw1 = 1'b1;
    write_data1 = 32'h0234;
    @(negedge clk);
    en_mw0 = 1'b0;
    en_mw1 = 1'b0;
    check("dual bus en", {31'd0, en_out}, 32'd1);
    check("dual bus data", write_data_out, 32'h1234);
    @(negedge clk);

    // Back-to-back issue accepted in the DONE cycle
    issue(4'd0, 32'h0, 3'd0, 32'd1, 3'd0, 32'd2, 5'd9);
    @(negedge clk);
    en_in = 1'b0;
    @(negedge clk);
    check("b2b first en", {31'd0, en_out}, 32'd1);
    check("b2b first data", write_data_out, 32'd3);
    issue(4'd0, 32'h0, 3'd0, 32'd10, 3'd0, 32'd20, 5'd10);
    @(negedge clk);
    en_in = 1'b0;
    check("b2b gap en", {31'd0, en_out}, 32'd0);
    check("b2b busy", {31'd0, busy_out}, 32'd1);
    @(negedge clk);
    check("b2b second en", {31'd0, en_out}, 32'd1);
    check("b2b second data", write_data_out, 32'd30);
    check("b2b second addr", {27'd0, reg_write_addr_out}, 32'd10);
    @(negedge clk);

    // Flush while waiting on bus 0, then bus 0 fires
    issue(4'd0, 32'h0, 3'd0, 32'd1, 3'd1, 32'd0, 5'd11);
    @(negedge clk);
    en_in = 1'b0;
    clear_in = 1'b1;
    @(negedge clk);
    clear_in = 1'b0;
    check("clear busy", {31'd0, busy_out}, 32'd0);
    en_mw0 = 1'b1;
    write_data0 = 32'd77;
    @(negedge clk);
    en_mw0 = 1'b0;
    check("clear no en", {31'd0, en_out}, 32'd0);
    check("clear idle", {31'd0, busy_out}, 32'd0);
    @(negedge clk);
    check("clear no en2", {31'd0, en_out}, 32'd0);

    // Flush overrides a simultaneous issue
    issue(4'd0, 32'h0, 3'd0, 32'd1, 3'd0, 32'd1, 5'd12);
    clear_in = 1'b1;
    @(negedge clk);
    en_in = 1'b0;
    clear_in = 1'b0;
    check("clear vs issue busy", {31'd0, busy_out}, 32'd0);
    @(negedge clk);
    check("clear vs issue en", {31'd0, en_out}, 32'd0);

    // Async reset in the DONE cycle
    issue(4'd0, 32'h0, 3'd0, 32'd40, 3'd0, 32'd2, 5'd13);
    @(negedge clk);
    en_in = 1'b0;
    @(negedge clk);
    check("pre-rst en", {31'd0, en_out}, 32'd1);
    check("pre-rst data", write_data_out, 32'd42);
    #2;
    rst = 1'b1;
    #1;
    check("async rst en", {31'd0, en_out}, 32'd0);
    check("async rst data", write_data_out, 32'd0);
    check("async rst addr", {27'd0, reg_write_addr_out}, 32'd0);
    check("async rst busy", {31'd0, busy_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
